// File: rtl/extender_if.sv
// extender_if -- groups the extender's data signals into one bundle.
//
// Signals:
//   Imm16      [15:0]  immediate field to be extended
//   ExtRes             extension mode (0 = zero-extend, 1 = sign-extend)
//   ExtResult  [31:0]  extended immediate, combinational
//   ExtResultQ [31:0]  registered copy of ExtResult
//   ExtNeg             registered flag, 1 when ExtResultQ is negative
//
// The master drives the immediate and the mode and observes the results.
// The slave is the extender itself.
interface extender_if;
  logic [15:0] Imm16;
  logic        ExtRes;
  logic [31:0] ExtResult;
  logic [31:0] ExtResultQ;
  logic        ExtNeg;

  modport master (
    output Imm16,
    output ExtRes,
    input  ExtResult,
    input  ExtResultQ,
    input  ExtNeg
  );

  modport slave (
    input  Imm16,
    input  ExtRes,
    output ExtResult,
    output ExtResultQ,
    output ExtNeg
  );
endinterface

// File: rtl/extender.sv
// extender -- widens a 16-bit immediate to 32 bits.
//
// Ports:
//   clk    in   single clock, registered outputs update on its rising edge
//   reset  in   synchronous, active-high; clears ExtResultQ and ExtNeg only
//   bus    slave modport of extender_if:
//            Imm16, ExtRes in; ExtResult (combinational), ExtResultQ and
//            ExtNeg (registered, one-cycle latency) out
//
// ExtResult never depends on clk or reset; it follows its inputs even while
// reset is held.
module extender (
  input  logic           clk,
  input  logic           reset,
  extender_if.slave      bus
);

  logic [31:0] extResult_s;
  logic [31:0] extResultQ_r;
  logic        extNeg_r;

  // Upper half is either all zeros or 16 copies of the immediate's sign bit.
  function automatic logic [31:0] extendImm(input logic [15:0] imm,
                                            input logic        signMode);
    logic [15:0] upper;
    if (signMode) begin
      upper = {16{imm[15]}};
    end else begin
      upper = 16'h0000;
    end
    return {upper, imm};
  endfunction

  // Combinational extension of the current immediate.
  always_comb begin
    extResult_s = extendImm(bus.Imm16, bus.ExtRes);
  end

  // Registered copy of the result and its sign flag; reset wins over the load.
  always_ff @(posedge clk) begin
    if (reset) begin
      extResultQ_r <= 32'h0000_0000;
      extNeg_r     <= 1'b0;
    end else begin
      extResultQ_r <= extResult_s;
      extNeg_r     <= extResult_s[31];
    end
  end

  assign bus.ExtResult  = extResult_s;
  assign bus.ExtResultQ = extResultQ_r;
  assign bus.ExtNeg     = extNeg_r;

endmodule

// File: tb/tb_extender.sv
// tb_extender -- self-checking bench for extender.
//
// Directed cases cover the documented values and boundaries, followed by
// randomized immediates, modes and occasional resets. Expected values come
// from an arithmetic reference model of the extension rules.
module tb_extender;

  logic clk;
  logic reset;

  extender_if bus ();

  extender dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checkCount;
  int errorCount;

  // Reference state for the registered outputs.
  logic [31:0] modelQ;
  logic        modelNeg;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkVal(input string tag, input logic [31:0] got,
                          input logic [31:0] exp);
    checkCount++;
    if (got !== exp) begin
      errorCount++;
      $display("FAIL %s got=%08h expected=%08h", tag, got, exp);
    end
  endtask

  // Reference: the value of the immediate read as unsigned or two's
  // complement, reduced modulo 2^32.
  function automatic logic [31:0] refExtend(input logic [15:0] imm,
                                            input logic mode);
    int unsigned v;
    v = imm;
    if (mode && imm >= 16'd32768) begin
      v = v + 32'hFFFF_0000;
    end
    return v;
  endfunction

  // Apply inputs away from the edge, check the combinational result, clock
  // once, then check the registered outputs against the model.
  task automatic step(input logic [15:0] imm, input logic mode,
                      input logic rst, input string tag);
    logic [31:0] exp;
    @(negedge clk);
    bus.Imm16  = imm;
    bus.ExtRes = mode;
    reset      = rst;
    #1;
    exp = refExtend(imm, mode);
    checkVal({tag, "_comb"}, bus.ExtResult, exp);
    @(posedge clk);
    if (rst) begin
      modelQ   = 32'h0000_0000;
      modelNeg = 1'b0;
    end else begin
      modelQ   = exp;
      modelNeg = (exp >= 32'h8000_0000);
    end
    #1;
    checkVal({tag, "_q"}, bus.ExtResultQ, modelQ);
    checkVal({tag, "_neg"}, {31'd0, bus.ExtNeg}, {31'd0, modelNeg});
    checkVal({tag, "_negmsb"}, {31'd0, bus.ExtNeg}, {31'd0, bus.ExtResultQ[31]});
  endtask

  initial begin
    checkCount = 0;
    errorCount = 0;
    modelQ     = 32'h0000_0000;
    modelNeg   = 1'b0;
    reset      = 1'b1;
    bus.Imm16  = 16'h0000;
    bus.ExtRes = 1'b0;

    // Reset state, with a sign-extending input held to show ExtResult
    // follows its inputs during reset.
    step(16'h8001, 1'b1, 1'b1, "reset");

    step(16'h1234, 1'b0, 1'b0, "zext_1234");
    checkVal("zext_1234_val", bus.ExtResultQ, 32'h0000_1234);
    step(16'h3456, 1'b0, 1'b0, "zext_3456");
    step(16'hFFFF, 1'b0, 1'b0, "zext_ffff");
    checkVal("zext_ffff_val", bus.ExtResultQ, 32'h0000_FFFF);

    // Mode-only change with the immediate held.
    @(negedge clk);
    bus.ExtRes = 1'b1;
    #1;
    checkVal("mode_switch_comb", bus.ExtResult, 32'hFFFF_FFFF);
    step(16'hFFFF, 1'b1, 1'b0, "sext_ffff");
    checkVal("sext_ffff_val", bus.ExtResultQ, 32'hFFFF_FFFF);

    // Reset mid-stream with ExtResultQ = FFFF_FFFF.
    step(16'hFFFF, 1'b1, 1'b1, "midreset");
    checkVal("midreset_comb_val", bus.ExtResult, 32'hFFFF_FFFF);
    checkVal("midreset_q_val", bus.ExtResultQ, 32'h0000_0000);

    step(16'h8000, 1'b1, 1'b0, "sext_8000");
    checkVal("sext_8000_val", bus.ExtResultQ, 32'hFFFF_8000);
    step(16'h7FFF, 1'b1, 1'b0, "sext_7fff");
    checkVal("sext_7fff_val", bus.ExtResultQ, 32'h0000_7FFF);
    step(16'h0000, 1'b1, 1'b0, "sext_0000");
    step(16'h0000, 1'b0, 1'b0, "zext_0000");
    step(16'h8000, 1'b0, 1'b0, "zext_8000");

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 300; i++) begin
      step(16'($urandom), 1'($urandom), ($urandom_range(0, 15) == 0), "rand");
    end

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule
